// File: rtl/breakout_pkg.sv
// Shared breakout definitions: play-state encoding and screen geometry.
// The state values are shown by the score overlay, so they are fixed numbers.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_MISS    = 3'd4,
    ST_OVER    = 3'd5,
    ST_WIN     = 3'd6
  } state_e;

  localparam int MAX_X          = 640;
  localparam int MAX_Y          = 480;
  localparam int TICK_Y_DEFAULT = 481;

endpackage

// File: rtl/frame_sampler.sv
// Button conditioner: 2-flop synchroniser, once-per-frame sampling and a rising-edge
// press pulse that is only asserted in the frame_tick cycle.
module frame_sampler (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  input  logic tick_i,
  output logic press_o
);

  logic sync1_q, sync2_q, sample_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (tick_i) sample_q <= sync2_q;
    end
  end

  // sync2_q is the sample being taken this tick, sample_q the one from the last frame
  assign press_o = tick_i & sync2_q & ~sample_q;

endmodule

// File: rtl/game_sequencer.sv
// Breakout play controller: frame tick from the scan position, button presses and the
// attract/serve/play/pause/miss/over/win sequencer that gates paddle and ball motion.
module game_sequencer
  import breakout_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int MISS_FRAMES = 60,
  parameter int END_FRAMES  = 180,
  parameter int TICK_Y      = TICK_Y_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       ball_miss,
  input  logic       bricks_clear,
  output logic       frame_tick,
  output logic       paddle_run,
  output logic       ball_run,
  output logic       ball_hold,
  output logic       bricks_load,
  output logic [2:0] lives_left,
  output logic [2:0] game_state
);

  logic   match, match_q;
  logic   start_press, pause_press;
  state_e state_q;
  logic [2:0] lives_q;
  logic [7:0] cnt_q;
  logic   paddle_run_q, ball_run_q, ball_hold_q, bricks_load_q;

  assign match = (pixel_y == 10'(TICK_Y)) && (pixel_x == 10'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match;
  end

  // The scan position dwells for several clocks; only the first one ticks.
  assign frame_tick = match & ~match_q & ~reset;

  frame_sampler u_start (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_start),
    .tick_i  (frame_tick),
    .press_o (start_press)
  );

  frame_sampler u_pause (
    .clock   (clock),
    .reset   (reset),
    .btn_i   (btn_pause),
    .tick_i  (frame_tick),
    .press_o (pause_press)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ATTRACT;
      lives_q       <= 3'd0;
      cnt_q         <= 8'd0;
      paddle_run_q  <= 1'b0;
      ball_run_q    <= 1'b0;
      ball_hold_q   <= 1'b0;
      bricks_load_q <= 1'b0;
    end else begin
      bricks_load_q <= 1'b0;
      // Enables follow the registered state, one cycle behind a transition.
      paddle_run_q  <= (state_q == ST_SERVE) || (state_q == ST_PLAY);
      ball_run_q    <= (state_q == ST_PLAY);
      ball_hold_q   <= (state_q == ST_SERVE);
      case (state_q)
        ST_ATTRACT: begin
          if (start_press) begin
            state_q       <= ST_SERVE;
            lives_q       <= 3'(LIVES);
            bricks_load_q <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (start_press) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (bricks_clear) begin
            state_q <= ST_WIN;
            cnt_q   <= 8'(END_FRAMES);
          end else if (ball_miss) begin
            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
            if (lives_q <= 3'd1) begin
              state_q <= ST_OVER;
              cnt_q   <= 8'(END_FRAMES);
            end else begin
              state_q <= ST_MISS;
              cnt_q   <= 8'(MISS_FRAMES);
            end
          end else if (pause_press) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pause_press) state_q <= ST_PLAY;
        end
        ST_MISS: begin
          if (frame_tick) begin
            if (cnt_q <= 8'd1) begin
              state_q <= ST_SERVE;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_OVER, ST_WIN: begin
          if (frame_tick) begin
            if (start_press || cnt_q <= 8'd1) begin
              state_q <= ST_ATTRACT;
              cnt_q   <= 8'd0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= ST_ATTRACT;
      endcase
    end
  end

  assign paddle_run  = paddle_run_q;
  assign ball_run    = ball_run_q;
  assign ball_hold   = ball_hold_q;
  assign bricks_load = bricks_load_q;
  assign lives_left  = lives_q;
  assign game_state  = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Frame-level bench for game_sequencer: a rules model predicts each state change with
// its frame number; a monitor pops those predictions as the DUT's state changes.
module tb_game_sequencer;

  localparam int LIVES       = 3;
  localparam int MISS_FRAMES = 60;
  localparam int END_FRAMES  = 180;
  localparam int TICK_Y      = 481;

  localparam int S_ATTRACT = 0;
  localparam int S_SERVE   = 1;
  localparam int S_PLAY    = 2;
  localparam int S_PAUSE   = 3;
  localparam int S_MISS    = 4;
  localparam int S_OVER    = 5;
  localparam int S_WIN     = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       btn_start, btn_pause, ball_miss, bricks_clear;
  logic       frame_tick, paddle_run, ball_run, ball_hold, bricks_load;
  logic [2:0] lives_left, game_state;

  game_sequencer #(
    .LIVES       (LIVES),
    .MISS_FRAMES (MISS_FRAMES),
    .END_FRAMES  (END_FRAMES),
    .TICK_Y      (TICK_Y)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .ball_miss    (ball_miss),
    .bricks_clear (bricks_clear),
    .frame_tick   (frame_tick),
    .paddle_run   (paddle_run),
    .ball_run     (ball_run),
    .ball_hold    (ball_hold),
    .bricks_load  (bricks_load),
    .lives_left   (lives_left),
    .game_state   (game_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int frame;
    int st;
    int lv;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ticks_issued = 0;
  int   ticks_seen = 0;

  // Reference model state
  int m_state = S_ATTRACT;
  int m_lives = 0;
  int m_cnt = 0;
  bit m_start_prev = 1'b0;
  bit m_pause_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input bit tick, input bit sp, input bit pp,
                             input bit miss, input bit clr);
    int   ns;
    exp_t e;
    ns = m_state;
    if (m_state == S_ATTRACT) begin
      if (sp) begin ns = S_SERVE; m_lives = LIVES; end
    end else if (m_state == S_SERVE) begin
      if (sp) ns = S_PLAY;
    end else if (m_state == S_PLAY) begin
      if (clr) begin
        ns = S_WIN; m_cnt = END_FRAMES;
      end else if (miss) begin
        if (m_lives > 0) m_lives = m_lives - 1;
        if (m_lives == 0) begin ns = S_OVER; m_cnt = END_FRAMES; end
        else begin ns = S_MISS; m_cnt = MISS_FRAMES; end
      end else if (pp) begin
        ns = S_PAUSE;
      end
    end else if (m_state == S_PAUSE) begin
      if (pp) ns = S_PLAY;
    end else if (m_state == S_MISS) begin
      if (tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) ns = S_SERVE;
      end
    end else begin
      if (tick) begin
        m_cnt = m_cnt - 1;
        if (sp || m_cnt == 0) ns = S_ATTRACT;
      end
    end
    if (ns != m_state) begin
      m_state = ns;
      e.frame = ticks_issued;
      e.st    = ns;
      e.lv    = m_lives;
      q.push_back(e);
    end
  endtask

  // Monitor: every observed state change must match the next prediction.
  int   last_state = 0;
  int   stable = 0;
  bit   bl_exp;
  exp_t mon_e;

  always @(negedge clock) begin
    if (reset) begin
      last_state = S_ATTRACT;
      stable     = 0;
    end else begin
      bl_exp = 1'b0;
      if (frame_tick) ticks_seen++;
      if (int'(game_state) != last_state) begin
        bl_exp = (last_state == S_ATTRACT) && (int'(game_state) == S_SERVE);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_transition: got state %0d, expected state %0d (t=%0t)",
                   game_state, last_state, $time);
        end else begin
          mon_e = q.pop_front();
          chk("state", int'(game_state), mon_e.st);
          chk("lives", int'(lives_left), mon_e.lv);
          chk("transition_frame", ticks_seen, mon_e.frame);
        end
        last_state = int'(game_state);
        stable     = 0;
      end else if (stable < 100) begin
        stable++;
      end
      if (bricks_load || bl_exp) chk("bricks_load", int'(bricks_load), int'(bl_exp));
      if (frame_tick && stable >= 2) begin
        chk("paddle_run", int'(paddle_run),
            int'(last_state == S_SERVE || last_state == S_PLAY));
        chk("ball_run", int'(ball_run), int'(last_state == S_PLAY));
        chk("ball_hold", int'(ball_hold), int'(last_state == S_SERVE));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_pixel();
    pixel_x = 10'($urandom_range(0, 639));
    pixel_y = 10'($urandom_range(0, 480));
  endtask

  // One video frame: buttons set early, 4-clock tick dwell, then an event slot.
  task automatic frame(input bit st, input bit pa, input bit miss, input bit clr,
                       input bit on_tick);
    bit sp, pp;
    btn_start = st;
    btn_pause = pa;
    for (int i = 0; i < 3; i++) begin
      rand_pixel();
      cyc();
    end
    pixel_x      = 10'd0;
    pixel_y      = 10'(TICK_Y);
    ball_miss    = miss & on_tick;
    bricks_clear = clr & on_tick;
    cyc();
    ticks_issued++;
    sp = st && !m_start_prev;
    pp = pa && !m_pause_prev;
    m_start_prev = st;
    m_pause_prev = pa;
    model_apply(1'b1, sp, pp, miss && on_tick, clr && on_tick);
    ball_miss    = 1'b0;
    bricks_clear = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    rand_pixel();
    ball_miss    = miss & ~on_tick;
    bricks_clear = clr & ~on_tick;
    cyc();
    model_apply(1'b0, 1'b0, 1'b0, miss && !on_tick, clr && !on_tick);
    ball_miss    = 1'b0;
    bricks_clear = 1'b0;
    cyc();
    chk("tick_count", ticks_seen, ticks_issued);
  endtask

  task automatic idle();
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic run_until(input int target, input int cap);
    for (int i = 0; i < cap && m_state != target; i++) idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(game_state), 0);
    chk({tag, "_lives"}, int'(lives_left), 0);
    chk({tag, "_outputs"},
        int'({frame_tick, paddle_run, ball_run, ball_hold, bricks_load}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    pixel_x      = 10'd5;
    pixel_y      = 10'd5;
    btn_start    = 1'b0;
    btn_pause    = 1'b0;
    ball_miss    = 1'b0;
    bricks_clear = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    cyc();
    reset = 1'b0;

    // Idle scan: nothing should happen.
    for (int i = 0; i < 3; i++) idle();

    // Held start: one press only, then release and press again.
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    press_start();

    // Three misses: two freezes of MISS_FRAMES, then game over and back to attract.
    for (int i = 0; i < 3; i++) begin
      frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < 2) begin
        run_until(S_SERVE, MISS_FRAMES + 5);
        press_start();
      end
    end
    run_until(S_ATTRACT, END_FRAMES + 5);

    // Miss and clear together win without losing a life; start ends the banner early.
    press_start();
    press_start();
    frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    press_start();

    // Pause, ignored start, resume.
    press_start();
    press_start();
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    press_start();
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // Miss on the same edge as a pause press: the miss wins.
    frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < MISS_FRAMES && !(m_state == S_MISS && m_cnt == 30); i++) idle();

    // Asynchronous reset in the middle of the freeze.
    chk("pending_before_reset", q.size(), 0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    m_state      = S_ATTRACT;
    m_lives      = 0;
    m_cnt        = 0;
    m_start_prev = 1'b0;
    m_pause_prev = 1'b0;
    btn_start    = 1'b0;
    btn_pause    = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    idle();
    press_start();
    press_start();

    // Random play.
    for (int i = 0; i < 300; i++) begin
      frame(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
            ($urandom % 8) == 0, ($urandom % 3) == 0);
    end
    idle();
    idle();
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
